// File: rtl/add_serial_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package add_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int ncyc_of(input int width, input int digit);
        return width / digit;
    endfunction

    function automatic int count_width(input int width, input int digit);
        return $clog2(width / digit + 1);
    endfunction

endpackage

// File: rtl/add_serial_param_slice.sv
// Combinational DIGIT-bit ripple slice; also exposes the carry into its MSB.
module digit_adder_slice #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [DIGIT:0] sum;

    always_comb begin
        sum      = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
        s        = sum[DIGIT-1:0];
        cout     = sum[DIGIT];
        // Carry into the MSB recovered from the MSB's sum bit and operands.
        c_msb_in = sum[DIGIT-1] ^ x[DIGIT-1] ^ y[DIGIT-1];
    end

endmodule

// File: rtl/add_serial_param.sv
// Digit-serial adder/subtractor: captures operands on start, adds DIGIT bits
// per cycle LSB first, reports carry-out and signed overflow. WIDTH >= 2, DIGIT | WIDTH.
module add_serial_param
    import add_serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int NCYC = ncyc_of(WIDTH, DIGIT);
    localparam int CW   = count_width(WIDTH, DIGIT);

    state_t           state, state_next;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic             carry;
    logic [CW-1:0]    count;

    logic [DIGIT-1:0] s_digit;
    logic             s_cout, s_cmsb;
    logic             start, last;
    logic [WIDTH-1:0] out_shift;

    digit_adder_slice #(.DIGIT(DIGIT)) u_slice (
        .x        (a_reg[DIGIT-1:0]),
        .y        (b_reg[DIGIT-1:0]),
        .cin      (carry),
        .s        (s_digit),
        .cout     (s_cout),
        .c_msb_in (s_cmsb)
    );

    // New digits enter at the top so the result ends up LSB-aligned.
    generate
        if (DIGIT == WIDTH) begin : g_single
            assign out_shift = s_digit;
        end else begin : g_multi
            assign out_shift = {s_digit, out[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_comb begin
        start      = en && (state == IDLE || state == DONE);
        last       = (count == CW'(NCYC - 1));
        state_next = state;
        case (state)
            IDLE:    if (en) state_next = ADD;
            ADD:     if (last) state_next = DONE;
            DONE:    if (en) state_next = ADD;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == ADD);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            count <= '0;
            out   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            if (start) begin
                a_reg <= a;
                b_reg <= (sub == MODE_SUB) ? ~b : b;
                carry <= sub;
                count <= '0;
                out   <= '0;
                cout  <= 1'b0;
                ovf   <= 1'b0;
            end else if (state == ADD) begin
                out   <= out_shift;
                a_reg <= a_reg >> DIGIT;
                b_reg <= b_reg >> DIGIT;
                carry <= s_cout;
                count <= count + CW'(1);
                if (last) begin
                    cout <= s_cout;
                    ovf  <= s_cmsb ^ s_cout;
                end
            end
        end
    end

endmodule
